// File: rtl/writeback_stage_pkg.sv
// Shared CPU package for the writeback stage.
// Holds the result-source (wb_sel) encodings, the RV32I load funct3 codes,
// the writeback state enumeration and a small alignment-check helper.
package writeback_stage_pkg;

    // Result source selector carried down the pipeline with each instruction
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_e;

    // RV32I load width/sign codes; the reserved codes (011, 110, 111) behave as LW
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Writeback sequencing states
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

    // Byte loads are never misaligned, halfwords need an even address and
    // words (including the reserved codes) need a word-aligned address.
    function automatic logic load_misaligned(input logic [2:0] funct3,
                                             input logic [1:0] offset);
        logic result;
        case (funct3)
            F3_LB, F3_LBU: result = 1'b0;
            F3_LH, F3_LHU: result = offset[0];
            default:       result = (offset != 2'b00);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/writeback_stage_load_align_ext.sv
// load_align_ext: combinational load data extraction.
// Picks the byte or halfword addressed by the low address bits out of an
// aligned 32-bit memory word and sign- or zero-extends it to 32 bits.
// Ports:
//   funct3  - load width/sign code
//   offset  - byte offset within the word (address bits [1:0])
//   word    - aligned memory word
//   data    - extended load result
module load_align_ext
    import writeback_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Select the addressed byte and halfword, then extend according to the
    // load code; anything not a byte/halfword load returns the full word.
    always_comb begin
        sel_byte = word[7:0];
        case (offset)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = word[7:0];
        endcase

        sel_half = offset[1] ? word[31:16] : word[15:0];

        data = word;
        case (funct3)
            F3_LB:   data = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   data = {{16{sel_half[15]}}, sel_half};
            F3_LBU:  data = {24'd0, sel_byte};
            F3_LHU:  data = {16'd0, sel_half};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage writing results to the register file.
// ALU and link results commit one cycle after acceptance; loads wait in
// WAIT_MEM for the memory response and commit the cycle after it arrives.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   in_valid/in_ready - MEM/WB handshake (ready only in IDLE, low in reset)
//   in_rd, in_wb_sel, in_funct3, in_alu_result, in_pc_plus4 - instruction
//   mem_rsp_valid/mem_rsp_data - load response word
//   write_en, rd, wd  - register-file write port (registered)
//   load_misalign     - one-cycle misaligned-load pulse
//   retired           - retired-instruction counter
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_pc_plus4,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            write_en,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] wd,
    output logic            load_misalign,
    output logic [31:0]     retired
);

    wb_state_e   state;
    logic [4:0]  pend_rd;
    logic [2:0]  pend_funct3;
    logic [1:0]  pend_offset;
    logic [31:0] load_data;
    logic        accept;

    // Ready only while idle, and held low during the reset cycle so nothing
    // is taken while the stage is being cleared.
    assign in_ready = (state == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // Extraction works on the latched load attributes and the response word.
    load_align_ext u_load_align_ext (
        .funct3 (pend_funct3),
        .offset (pend_offset),
        .word   (mem_rsp_data),
        .data   (load_data)
    );

    // Main sequencer. write_en and load_misalign default low each cycle so
    // they are strictly single-cycle pulses; rd/wd hold when not writing.
    // retired counts every commit, including writes suppressed for x0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            write_en      <= 1'b0;
            rd            <= 5'd0;
            wd            <= '0;
            load_misalign <= 1'b0;
            retired       <= 32'd0;
            pend_rd       <= 5'd0;
            pend_funct3   <= 3'd0;
            pend_offset   <= 2'd0;
        end else begin
            write_en      <= 1'b0;
            load_misalign <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (wb_sel_e'(in_wb_sel))
                            WB_ALU: begin
                                write_en <= (in_rd != 5'd0);
                                rd       <= in_rd;
                                wd       <= in_alu_result;
                                retired  <= retired + 32'd1;
                            end
                            WB_PC4: begin
                                write_en <= (in_rd != 5'd0);
                                rd       <= in_rd;
                                wd       <= in_pc_plus4;
                                retired  <= retired + 32'd1;
                            end
                            WB_LOAD: begin
                                if (load_misaligned(in_funct3, in_alu_result[1:0])) begin
                                    load_misalign <= 1'b1;
                                end else begin
                                    pend_rd     <= in_rd;
                                    pend_funct3 <= in_funct3;
                                    pend_offset <= in_alu_result[1:0];
                                    state       <= ST_WAIT_MEM;
                                end
                            end
                            default: begin
                                retired <= retired + 32'd1;
                            end
                        endcase
                    end
                end
                ST_WAIT_MEM: begin
                    if (mem_rsp_valid) begin
                        write_en <= (pend_rd != 5'd0);
                        rd       <= pend_rd;
                        wd       <= load_data;
                        retired  <= retired + 32'd1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage. Inputs change one time
// unit after a rising edge; outputs are checked at the same point, so a
// value shown after edge N reflects what the stage registered at that edge.
module tb_writeback_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        write_en;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        load_misalign;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    writeback_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_wb_sel     (in_wb_sel),
        .in_funct3     (in_funct3),
        .in_alu_result (in_alu_result),
        .in_pc_plus4   (in_pc_plus4),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .write_en      (write_en),
        .rd            (rd),
        .wd            (wd),
        .load_misalign (load_misalign),
        .retired       (retired)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction on the MEM/WB inputs
    task automatic applyStimulus(input logic valid, input logic [1:0] sel,
                                 input logic [4:0] dest, input logic [2:0] f3,
                                 input logic [31:0] alu, input logic [31:0] pc4);
        in_valid      = valid;
        in_wb_sel     = sel;
        in_rd         = dest;
        in_funct3     = f3;
        in_alu_result = alu;
        in_pc_plus4   = pc4;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rst           = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        applyStimulus(1'b0, 2'b00, 5'd0, 3'd0, 32'd0, 32'd0);

        // Reset state, with in_ready low during reset
        step();
        step();
        checkOutput("rst_write_en", {31'd0, write_en}, 32'd0);
        checkOutput("rst_rd", {27'd0, rd}, 32'd0);
        checkOutput("rst_wd", wd, 32'd0);
        checkOutput("rst_misalign", {31'd0, load_misalign}, 32'd0);
        checkOutput("rst_retired", retired, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // ALU op rd=5
        applyStimulus(1'b1, 2'b00, 5'd5, 3'd0, 32'h1234_5678, 32'd0);
        step();
        in_valid = 1'b0;
        checkOutput("alu_write_en", {31'd0, write_en}, 32'd1);
        checkOutput("alu_rd", {27'd0, rd}, 32'd5);
        checkOutput("alu_wd", wd, 32'h1234_5678);
        checkOutput("alu_retired", retired, 32'd1);
        step();
        checkOutput("alu_pulse_end", {31'd0, write_en}, 32'd0);

        // LB offset 3, response two cycles after acceptance
        applyStimulus(1'b1, 2'b01, 5'd9, 3'b000, 32'h0000_1003, 32'd0);
        step();
        in_valid = 1'b0;
        checkOutput("lb_no_write_n1", {31'd0, write_en}, 32'd0);
        checkOutput("lb_ready_low_1", {31'd0, in_ready}, 32'd0);
        step();
        checkOutput("lb_ready_low_2", {31'd0, in_ready}, 32'd0);
        checkOutput("lb_no_write_n2", {31'd0, write_en}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h80FF_0011;
        step();
        mem_rsp_valid = 1'b0;
        checkOutput("lb_write_en", {31'd0, write_en}, 32'd1);
        checkOutput("lb_rd", {27'd0, rd}, 32'd9);
        checkOutput("lb_wd", wd, 32'hFFFF_FF80);
        checkOutput("lb_retired", retired, 32'd2);
        checkOutput("lb_ready_back", {31'd0, in_ready}, 32'd1);

        // Stale response while idle is dropped
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        checkOutput("stale_write_en", {31'd0, write_en}, 32'd0);
        checkOutput("stale_retired", retired, 32'd2);

        // LHU offset 2
        applyStimulus(1'b1, 2'b01, 5'd10, 3'b101, 32'h0000_2002, 32'd0);
        step();
        in_valid      = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hBEEF_0000;
        step();
        mem_rsp_valid = 1'b0;
        checkOutput("lhu_write_en", {31'd0, write_en}, 32'd1);
        checkOutput("lhu_wd", wd, 32'h0000_BEEF);
        checkOutput("lhu_retired", retired, 32'd3);

        // LW offset 2 is misaligned
        applyStimulus(1'b1, 2'b01, 5'd11, 3'b010, 32'h0000_3002, 32'd0);
        step();
        in_valid = 1'b0;
        checkOutput("lw_mis_pulse", {31'd0, load_misalign}, 32'd1);
        checkOutput("lw_mis_no_write", {31'd0, write_en}, 32'd0);
        checkOutput("lw_mis_retired", retired, 32'd3);
        checkOutput("lw_mis_idle", {31'd0, in_ready}, 32'd1);
        step();
        checkOutput("lw_mis_pulse_end", {31'd0, load_misalign}, 32'd0);

        // Back-to-back ALU ops to rd=0 then rd=7
        applyStimulus(1'b1, 2'b00, 5'd0, 3'd0, 32'hDEAD_0000, 32'd0);
        step();
        checkOutput("x0_no_write", {31'd0, write_en}, 32'd0);
        checkOutput("x0_retired", retired, 32'd4);
        applyStimulus(1'b1, 2'b00, 5'd7, 3'd0, 32'h0000_0077, 32'd0);
        step();
        in_valid = 1'b0;
        checkOutput("r7_write_en", {31'd0, write_en}, 32'd1);
        checkOutput("r7_rd", {27'd0, rd}, 32'd7);
        checkOutput("r7_wd", wd, 32'h0000_0077);
        checkOutput("r7_retired", retired, 32'd5);

        // JAL link value to rd=1
        applyStimulus(1'b1, 2'b10, 5'd1, 3'd0, 32'h0000_0800, 32'h0000_0104);
        step();
        in_valid = 1'b0;
        checkOutput("jal_write_en", {31'd0, write_en}, 32'd1);
        checkOutput("jal_rd", {27'd0, rd}, 32'd1);
        checkOutput("jal_wd", wd, 32'h0000_0104);
        checkOutput("jal_retired", retired, 32'd6);

        // Store/branch: retire, no write
        applyStimulus(1'b1, 2'b11, 5'd12, 3'd0, 32'h0000_0040, 32'd0);
        step();
        in_valid = 1'b0;
        checkOutput("none_write_en", {31'd0, write_en}, 32'd0);
        checkOutput("none_retired", retired, 32'd7);

        // LH offset 2, sign-extended
        applyStimulus(1'b1, 2'b01, 5'd13, 3'b001, 32'h0000_4002, 32'd0);
        step();
        in_valid      = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h8001_1234;
        step();
        mem_rsp_valid = 1'b0;
        checkOutput("lh_wd", wd, 32'hFFFF_8001);
        checkOutput("lh_retired", retired, 32'd8);

        // Reserved funct3 011 behaves as LW
        applyStimulus(1'b1, 2'b01, 5'd4, 3'b011, 32'h0000_5000, 32'd0);
        step();
        in_valid      = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hCAFE_BABE;
        step();
        mem_rsp_valid = 1'b0;
        checkOutput("rsv_write_en", {31'd0, write_en}, 32'd1);
        checkOutput("rsv_wd", wd, 32'hCAFE_BABE);
        checkOutput("rsv_retired", retired, 32'd9);

        // Reset while waiting for memory; the late response is ignored
        applyStimulus(1'b1, 2'b01, 5'd3, 3'b010, 32'h0000_6000, 32'd0);
        step();
        in_valid = 1'b0;
        checkOutput("wait_ready_low", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        step();
        checkOutput("rstw_write_en", {31'd0, write_en}, 32'd0);
        checkOutput("rstw_retired", retired, 32'd0);
        rst           = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1111_2222;
        step();
        mem_rsp_valid = 1'b0;
        checkOutput("post_rst_write_en", {31'd0, write_en}, 32'd0);
        checkOutput("post_rst_retired", retired, 32'd0);
        checkOutput("post_rst_idle", {31'd0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
